// File: rtl/soc_cpu_5_ocimem_pkg.sv
// Shared types and JTAG data-register field positions for the debug on-chip memory controller.
package soc_cpu_5_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_CAP  = 2'd2,
        WR      = 2'd3
    } ocimem_state_t;

    localparam int unsigned JDO_W           = 38;
    localparam int unsigned JDO_ADDR_MSB    = 34;
    localparam int unsigned JDO_ADDR_LSB    = 26;
    localparam int unsigned JDO_RD_BIT      = 35;
    localparam int unsigned JDO_CLR_ERR_BIT = 25;
    localparam int unsigned JDO_DATA_MSB    = 34;
    localparam int unsigned JDO_DATA_LSB    = 3;

    function automatic logic addr_out_of_range(input logic [8:0] addr, input int unsigned depth);
        return 32'(addr) >= depth;
    endfunction

endpackage

// File: rtl/soc_cpu_5_ocimem_ram.sv
// Inferred single-port DEPTHx32 synchronous RAM with a registered (1-cycle) read.
module soc_cpu_5_ocimem_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/soc_cpu_5_jtag_ocimem_ctrl.sv
// JTAG-side debug memory controller with a lower-priority CPU slave port on the same RAM.
// Optional feature macro: SOC_OCIMEM_CPU_PORT_EN (defined = CPU slave port functional).
module soc_cpu_5_jtag_ocimem_ctrl
    import soc_cpu_5_ocimem_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ocimem_state_t     state_q, state_d;
    logic [ADDR_W-1:0] MonAReg, mon_a_d;
    logic [31:0]       mon_d_d;
    logic              ready_d, err_d, err_set, err_clr;
    logic              any_strobe, jtag_oor;
    logic              jtag_ram_en, jtag_ram_we;
    logic              ram_en, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;
    logic              unused_jdo;

    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign jtag_oor   = addr_out_of_range(MonAReg, DEPTH);
    assign err_clr    = take_action_ocimem_a & jdo[JDO_CLR_ERR_BIT];
    assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            state_q       <= state_d;
            MonAReg       <= mon_a_d;
            MonDReg       <= mon_d_d;
            monitor_ready <= ready_d;
            monitor_error <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mon_a_d     = MonAReg;
        mon_d_d     = MonDReg;
        ready_d     = monitor_ready;
        err_set     = 1'b0;
        jtag_ram_en = 1'b0;
        jtag_ram_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_action_ocimem_b) begin
                    state_d = WR;
                    ready_d = 1'b0;
                    err_set = take_action_ocimem_a | take_no_action_ocimem_a;
                end else if (take_action_ocimem_a) begin
                    mon_a_d = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
                    err_set = take_no_action_ocimem_a;
                    if (jdo[JDO_RD_BIT]) begin
                        state_d = RD_ADDR;
                        ready_d = 1'b0;
                    end
                end else if (take_no_action_ocimem_a) begin
                    mon_a_d = MonAReg + ADDR_W'(1);
                    state_d = RD_ADDR;
                    ready_d = 1'b0;
                end
            end
            RD_ADDR: begin
                jtag_ram_en = ~jtag_oor;
                state_d     = RD_CAP;
                err_set     = any_strobe;
            end
            RD_CAP: begin
                // RAM output is consumed straight from the array register.
                mon_d_d = jtag_oor ? '0 : ram_rdata;
                ready_d = 1'b1;
                state_d = IDLE;
                err_set = any_strobe | jtag_oor;
            end
            WR: begin
                jtag_ram_en = ~jtag_oor;
                jtag_ram_we = ~jtag_oor;
                mon_a_d     = MonAReg + ADDR_W'(1);
                ready_d     = 1'b1;
                state_d     = IDLE;
                err_set     = any_strobe | jtag_oor;
            end
            default: state_d = IDLE;
        endcase
        // Clear takes effect first so a same-cycle error still latches.
        err_d = (monitor_error & ~err_clr) | err_set;
    end

`ifdef SOC_OCIMEM_CPU_PORT_EN
    logic cpu_req, cpu_oor, cpu_grant, cpu_rd_pend_q, cpu_rd_oor_q;

    assign cpu_req   = cpu_read | cpu_write;
    assign cpu_oor   = addr_out_of_range(cpu_address, DEPTH);
    // The data-return cycle of a read is not a new request.
    assign cpu_grant = cpu_req & (state_q == IDLE) & ~any_strobe & ~cpu_rd_pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rd_pend_q <= 1'b0;
            cpu_rd_oor_q  <= 1'b0;
        end else begin
            cpu_rd_pend_q <= cpu_grant & ~cpu_write;
            cpu_rd_oor_q  <= cpu_oor;
        end
    end

    assign cpu_readdata    = (cpu_rd_pend_q & ~cpu_rd_oor_q) ? ram_rdata : '0;
    assign cpu_waitrequest = ~cpu_rd_pend_q & cpu_req & ~(cpu_grant & cpu_write);
`else
    logic unused_cpu;

    assign unused_cpu      = &{1'b0, cpu_address, cpu_read, cpu_write, cpu_writedata};
    assign cpu_readdata    = '0;
    assign cpu_waitrequest = 1'b0;
`endif

    always_comb begin
        ram_en    = jtag_ram_en;
        ram_we    = jtag_ram_we;
        ram_addr  = MonAReg[RAM_AW-1:0];
        ram_wdata = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
`ifdef SOC_OCIMEM_CPU_PORT_EN
        if (cpu_grant) begin
            ram_en    = ~cpu_oor;
            ram_we    = cpu_write;
            ram_addr  = cpu_address[RAM_AW-1:0];
            ram_wdata = cpu_writedata;
        end
`endif
    end

    soc_cpu_5_ocimem_ram #(
        .DEPTH(DEPTH),
        .AW   (RAM_AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_soc_cpu_5_jtag_ocimem_ctrl.sv
// Self-checking bench: JTAG op table with a MonDReg scoreboard, plus corner-case sequences.
module tb_soc_cpu_5_jtag_ocimem_ctrl;
    import soc_cpu_5_ocimem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta_a, tna_a, ta_b;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [8:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata, cpu_readdata;
    logic        cpu_waitrequest;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic        rd_outstanding = 1'b0;

    always #5 clk = ~clk;

    soc_cpu_5_jtag_ocimem_ctrl #(
        .DEPTH (256),
        .ADDR_W(9)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (ta_a),
        .take_no_action_ocimem_a(tna_a),
        .take_action_ocimem_b   (ta_b),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error),
        .cpu_address            (cpu_address),
        .cpu_read               (cpu_read),
        .cpu_write              (cpu_write),
        .cpu_writedata          (cpu_writedata),
        .cpu_readdata           (cpu_readdata),
        .cpu_waitrequest        (cpu_waitrequest)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_cmd(input logic rd, input logic [8:0] addr, input logic clr);
        return {2'b00, rd, addr, clr, 25'd0};
    endfunction

    function automatic logic [37:0] jdo_wr(input logic [31:0] data);
        return {3'b000, data, 3'b000};
    endfunction

    // Scoreboard: expected MonDReg values are popped when a read completes.
    always @(negedge clk) begin
        if (rd_outstanding && monitor_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check("sb_MonDReg", MonDReg, exp_q.pop_front());
            end
            rd_outstanding = 1'b0;
        end
    end

    task automatic wait_ready(input string name, input int exp_lat);
        int lat = 1;
        while (!monitor_ready && lat < 20) begin
            tick();
            lat++;
        end
        check(name, lat, exp_lat);
        @(negedge clk);
        #1;
    endtask

    task automatic jtag_seta(input logic [8:0] addr, input logic clr);
        ta_a = 1'b1;
        jdo  = jdo_cmd(1'b0, addr, clr);
        tick();
        ta_a = 1'b0;
        check("seta_ready", monitor_ready, 1);
    endtask

    task automatic jtag_write(input logic [31:0] data);
        ta_b = 1'b1;
        jdo  = jdo_wr(data);
        tick();
        ta_b = 1'b0;
        check("wr_busy", monitor_ready, 0);
        wait_ready("wr_latency", 2);
    endtask

    task automatic jtag_read(input logic next, input logic [8:0] addr, input logic [31:0] exp);
        if (next) tna_a = 1'b1;
        else      ta_a  = 1'b1;
        jdo = jdo_cmd(1'b1, addr, 1'b0);
        tick();
        ta_a  = 1'b0;
        tna_a = 1'b0;
        check("rd_busy", monitor_ready, 0);
        exp_q.push_back(exp);
        rd_outstanding = 1'b1;
        wait_ready("rd_latency", 3);
    endtask

    typedef enum int {OP_SETA, OP_WRB, OP_RDA, OP_RDN} op_e;
    typedef struct {
        op_e         op;
        logic [8:0]  addr;
        logic [31:0] data;
        logic        clr;
        logic [8:0]  exp_addr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_SETA, 9'h010, 32'h0,        1'b0, 9'h010, 1'b0};
        vecs[1]  = '{OP_WRB,  9'h000, 32'hCAFEF00D, 1'b0, 9'h011, 1'b0};
        vecs[2]  = '{OP_WRB,  9'h000, 32'h12345678, 1'b0, 9'h012, 1'b0};
        vecs[3]  = '{OP_RDA,  9'h010, 32'hCAFEF00D, 1'b0, 9'h010, 1'b0};
        vecs[4]  = '{OP_RDN,  9'h000, 32'h12345678, 1'b0, 9'h011, 1'b0};
        vecs[5]  = '{OP_SETA, 9'h0FF, 32'h0,        1'b0, 9'h0FF, 1'b0};
        vecs[6]  = '{OP_WRB,  9'h000, 32'hA5A5A5A5, 1'b0, 9'h100, 1'b0};
        vecs[7]  = '{OP_SETA, 9'h1FF, 32'h0,        1'b0, 9'h1FF, 1'b0};
        vecs[8]  = '{OP_WRB,  9'h000, 32'hDEADBEEF, 1'b0, 9'h000, 1'b1};
        vecs[9]  = '{OP_WRB,  9'h000, 32'h0BADF00D, 1'b0, 9'h001, 1'b1};
        vecs[10] = '{OP_RDA,  9'h0FF, 32'hA5A5A5A5, 1'b0, 9'h0FF, 1'b1};
        vecs[11] = '{OP_RDN,  9'h000, 32'h00000000, 1'b0, 9'h100, 1'b1};
        vecs[12] = '{OP_SETA, 9'h000, 32'h0,        1'b1, 9'h000, 1'b0};
        vecs[13] = '{OP_RDA,  9'h1FF, 32'h00000000, 1'b0, 9'h1FF, 1'b1};
        vecs[14] = '{OP_RDN,  9'h000, 32'h0BADF00D, 1'b0, 9'h000, 1'b1};
        vecs[15] = '{OP_SETA, 9'h010, 32'h0,        1'b1, 9'h010, 1'b0};
        vecs[16] = '{OP_RDA,  9'h000, 32'h0BADF00D, 1'b0, 9'h000, 1'b0};

        reset_n = 1'b0; jdo = '0; ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
        cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        check("rst_MonDReg", MonDReg, 32'h0);
        check("rst_ready", monitor_ready, 1);
        check("rst_error", monitor_error, 0);
        check("rst_MonAReg", 32'(dut.MonAReg), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_cpu_readdata", cpu_readdata, 32'h0);
        check("rst_cpu_waitreq", cpu_waitrequest, 0);

        for (int i = 0; i < 17; i++) begin
            case (vecs[i].op)
                OP_SETA: jtag_seta(vecs[i].addr, vecs[i].clr);
                OP_WRB:  jtag_write(vecs[i].data);
                OP_RDA:  jtag_read(1'b0, vecs[i].addr, vecs[i].data);
                default: jtag_read(1'b1, vecs[i].addr, vecs[i].data);
            endcase
            check($sformatf("v%0d_MonAReg", i), 32'(dut.MonAReg), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_error", i), monitor_error, vecs[i].exp_err);
        end

        // Write strobe during RD_ADDR is dropped and flags an error.
        jtag_seta(9'h030, 1'b0);
        jtag_write(32'h30303030);
        ta_a = 1'b1;
        jdo  = jdo_cmd(1'b1, 9'h030, 1'b0);
        tick();
        ta_a = 1'b0;
        exp_q.push_back(32'h30303030);
        rd_outstanding = 1'b1;
        ta_b = 1'b1;
        tick();
        ta_b = 1'b0;
        wait_ready("drop_rd_latency", 2);
        check("drop_error", monitor_error, 1);
        check("drop_MonAReg", 32'(dut.MonAReg), 32'h030);
        jtag_read(1'b0, 9'h030, 32'h30303030);
        jtag_seta(9'h000, 1'b1);
        check("clr_error", monitor_error, 0);

        // Simultaneous a + no_action: a wins, error set.
        ta_a  = 1'b1;
        tna_a = 1'b1;
        jdo   = jdo_cmd(1'b0, 9'h040, 1'b0);
        tick();
        ta_a  = 1'b0;
        tna_a = 1'b0;
        check("multi_a_MonAReg", 32'(dut.MonAReg), 32'h040);
        check("multi_a_error", monitor_error, 1);

        // Simultaneous b + a: write at current address, a dropped.
        jtag_seta(9'h020, 1'b1);
        check("clr2_error", monitor_error, 0);
        ta_b = 1'b1;
        ta_a = 1'b1;
        jdo  = jdo_wr(32'h13579BDF);
        tick();
        ta_b = 1'b0;
        ta_a = 1'b0;
        check("multi_b_busy", monitor_ready, 0);
        wait_ready("multi_b_latency", 2);
        check("multi_b_MonAReg", 32'(dut.MonAReg), 32'h021);
        check("multi_b_error", monitor_error, 1);
        jtag_read(1'b0, 9'h020, 32'h13579BDF);
        jtag_seta(9'h010, 1'b1);

`ifdef SOC_OCIMEM_CPU_PORT_EN
        begin
            int n;
            // CPU write completes in the grant cycle.
            cpu_write = 1'b1; cpu_address = 9'h050; cpu_writedata = 32'h5050A0A0;
            #1;
            check("cpu_wr_waitreq", cpu_waitrequest, 0);
            tick();
            cpu_write = 1'b0;
            jtag_read(1'b0, 9'h050, 32'h5050A0A0);

            // Plain CPU read: two cycles to waitrequest low.
            cpu_read = 1'b1; cpu_address = 9'h050;
            n = 1;
            #1;
            while (cpu_waitrequest && n < 20) begin @(posedge clk); #2; n++; end
            check("cpu_rd_cycles", n, 2);
            check("cpu_rd_data", cpu_readdata, 32'h5050A0A0);
            tick();
            cpu_read = 1'b0;

            // CPU read collides with a JTAG write strobe to the same word.
            jtag_seta(9'h010, 1'b0);
            ta_b = 1'b1; jdo = jdo_wr(32'h600DCAFE);
            cpu_read = 1'b1; cpu_address = 9'h010;
            #1;
            check("cpu_blk_waitreq", cpu_waitrequest, 1);
            @(posedge clk); #1;
            ta_b = 1'b0;
            #1;
            n = 2;
            while (cpu_waitrequest && n < 20) begin @(posedge clk); #2; n++; end
            check("cpu_blk_cycles", n, 4);
            check("cpu_blk_data", cpu_readdata, 32'h600DCAFE);
            check("cpu_blk_ready", monitor_ready, 1);
            tick();
            cpu_read = 1'b0;

            // Out-of-range CPU read returns zero without touching the error flag.
            cpu_read = 1'b1; cpu_address = 9'h1F0;
            n = 1;
            #1;
            while (cpu_waitrequest && n < 20) begin @(posedge clk); #2; n++; end
            check("cpu_oor_cycles", n, 2);
            check("cpu_oor_data", cpu_readdata, 32'h0);
            tick();
            cpu_read = 1'b0;

            // Out-of-range CPU write must not alias onto word 0x0F0.
            jtag_seta(9'h0F0, 1'b0);
            jtag_write(32'hF0F0F0F0);
            cpu_write = 1'b1; cpu_address = 9'h1F0; cpu_writedata = 32'h0000BAD0;
            tick();
            cpu_write = 1'b0;
            jtag_read(1'b0, 9'h0F0, 32'hF0F0F0F0);
            check("cpu_oor_error", monitor_error, 0);
        end
`else
        // Port disabled: requests are ignored and outputs stay idle.
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 9'h010; cpu_writedata = 32'h0000BAD0;
        #1;
        check("nocpu_waitreq", cpu_waitrequest, 0);
        check("nocpu_readdata", cpu_readdata, 32'h0);
        tick();
        tick();
        check("nocpu_waitreq2", cpu_waitrequest, 0);
        check("nocpu_readdata2", cpu_readdata, 32'h0);
        cpu_read = 1'b0; cpu_write = 1'b0;
        jtag_read(1'b0, 9'h010, 32'hCAFEF00D);
        check("nocpu_error", monitor_error, 0);
`endif

        // Asynchronous reset while in WR.
        ta_a = 1'b1; tna_a = 1'b1; jdo = jdo_cmd(1'b0, 9'h060, 1'b0);
        tick();
        ta_a = 1'b0; tna_a = 1'b0;
        check("prerst_error", monitor_error, 1);
        ta_b = 1'b1;
        jdo  = jdo_wr(32'h66666666);
        tick();
        ta_b = 1'b0;
        check("prerst_ready", monitor_ready, 0);
        check("prerst_state", 32'(dut.state_q), 32'(WR));
        reset_n = 1'b0;
        #1;
        check("midrst_ready", monitor_ready, 1);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        check("midrst_MonAReg", 32'(dut.MonAReg), 32'h0);
        check("midrst_MonDReg", MonDReg, 32'h0);
        check("midrst_error", monitor_error, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
